// File: rtl/pipe_mem_arbiter_if.sv
// ============================================================================
// Module  : pipe_mem_arbiter_if
// Purpose : Fetch, data and memory handshake bundle for pipe_mem_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_mem_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             if_req;
   logic [WIDTH-1:0] if_addr;
   logic [WIDTH-1:0] if_rdata;
   logic             if_ready;
   logic             d_req;
   logic             d_we;
   logic [WIDTH-1:0] d_addr;
   logic [WIDTH-1:0] d_wdata;
   logic [WIDTH-1:0] d_rdata;
   logic             d_ready;
   logic             stall_if;
   logic             stall_d;
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ack;
   logic [1:0]       grant;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_d,
             mem_req, mem_we, mem_addr, mem_wdata, grant
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_d,
             mem_req, mem_we, mem_addr, mem_wdata, grant
   );
endinterface

`default_nettype wire

// File: rtl/pipe_mem_arbiter.sv
// ============================================================================
// Module  : pipe_mem_arbiter
// Purpose : Shares one single-ported memory between IF and MEM stages.
//           Data accesses win by default; a starvation counter bounds IF waits.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_mem_arbiter #(
   parameter int WIDTH  = 32,
   parameter int STARVE = 2
) (
   input  wire               clock,
   input  wire               resetn,
   pipe_mem_arbiter_if.slave bus
);

   localparam int CW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
   localparam logic [CW-1:0] c_starve_max = CW'(STARVE);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_I = 2'd1,
      S_BUSY_D = 2'd2
   } state_e;

   state_e           state_q;
   logic [CW-1:0]    starve_q;
   logic [CW-1:0]    starve_d;
   logic             mem_req_q;
   logic             mem_we_q;
   logic [WIDTH-1:0] mem_addr_q;
   logic [WIDTH-1:0] mem_wdata_q;
   logic [1:0]       grant_q;
   logic             w_starved;
   logic             w_if_ready;
   logic             w_d_ready;

   assign w_starved = (starve_q == c_starve_max);

   // Counter value to load when D is granted: counts only while IF is waiting.
   always_comb begin
      starve_d = '0;
      if (bus.if_req) begin
         starve_d = w_starved ? starve_q : starve_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         starve_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         grant_q     <= 2'b00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.if_req && (!bus.d_req || w_starved)) begin
                  state_q    <= S_BUSY_I;
                  mem_req_q  <= 1'b1;
                  grant_q    <= 2'b01;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= bus.if_addr;
                  starve_q   <= '0;
               end else if (bus.d_req) begin
                  state_q     <= S_BUSY_D;
                  mem_req_q   <= 1'b1;
                  grant_q     <= 2'b10;
                  mem_we_q    <= bus.d_we;
                  mem_addr_q  <= bus.d_addr;
                  mem_wdata_q <= bus.d_wdata;
                  starve_q    <= starve_d;
               end
            end
            S_BUSY_I, S_BUSY_D: begin
               if (bus.mem_ack) begin
                  state_q   <= S_IDLE;
                  mem_req_q <= 1'b0;
                  grant_q   <= 2'b00;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               mem_req_q <= 1'b0;
               grant_q   <= 2'b00;
            end
         endcase
      end
   end

   // Completion is combinational so the requester sees ready in the ack cycle.
   assign w_if_ready = (state_q == S_BUSY_I) && bus.mem_ack;
   assign w_d_ready  = (state_q == S_BUSY_D) && bus.mem_ack;

   assign bus.if_ready  = w_if_ready;
   assign bus.d_ready   = w_d_ready;
   assign bus.if_rdata  = bus.mem_rdata;
   assign bus.d_rdata   = bus.mem_rdata;
   assign bus.stall_if  = bus.if_req & ~w_if_ready;
   assign bus.stall_d   = bus.d_req & ~w_d_ready;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.grant     = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mem_arbiter.sv
// ============================================================================
// Module  : tb_pipe_mem_arbiter
// Purpose : Directed self-checking bench for pipe_mem_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_mem_arbiter;

   logic clock;
   logic resetn;
   int   errors;
   int   checks;

   pipe_mem_arbiter_if #(.WIDTH(32)) bus ();

   pipe_mem_arbiter #(.WIDTH(32), .STARVE(2)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      bus.if_req = 1'b1;
      bus.if_addr = 32'h0000_0010;
      tick();
      tick();
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
      checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", bus.grant); end
      checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL rst_if_ready: got %b want 0", bus.if_ready); end
      checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
      checks++; if (bus.stall_if !== 1'b1) begin errors++; $display("FAIL rst_stall_if: got %b want 1", bus.stall_if); end
      bus.if_req = 1'b0;
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_if_only();
      bus.if_req = 1'b1;
      bus.if_addr = 32'h0000_0040;
      tick();
      checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL ifo_grant: got %b want 01", bus.grant); end
      checks++; if (bus.mem_addr !== 32'h40) begin errors++; $display("FAIL ifo_mem_addr: got %h want 40", bus.mem_addr); end
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL ifo_mem_we: got %b want 0", bus.mem_we); end
      checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL ifo_early_ready: got %b want 0", bus.if_ready); end
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h8C22_0004;
      #1;
      checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL ifo_ready: got %b want 1", bus.if_ready); end
      checks++; if (bus.if_rdata !== 32'h8C22_0004) begin errors++; $display("FAIL ifo_rdata: got %h want 8c220004", bus.if_rdata); end
      checks++; if (bus.stall_if !== 1'b0) begin errors++; $display("FAIL ifo_stall: got %b want 0", bus.stall_if); end
      tick();
      bus.if_req = 1'b0;
      bus.mem_ack = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b0 || bus.if_ready !== 1'b0) begin errors++; $display("FAIL ifo_done: got req=%b rdy=%b want 0 0", bus.mem_req, bus.if_ready); end
   endtask

   task automatic test_simultaneous();
      bus.d_req = 1'b1;
      bus.d_we = 1'b1;
      bus.d_addr = 32'h0000_0100;
      bus.d_wdata = 32'hDEAD_BEEF;
      bus.if_req = 1'b1;
      bus.if_addr = 32'h0000_0044;
      tick();
      checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL sim_grant_d: got %b want 10", bus.grant); end
      checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL sim_we: got %b want 1", bus.mem_we); end
      checks++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sim_wdata: got %h want deadbeef", bus.mem_wdata); end
      checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL sim_addr_d: got %h want 100", bus.mem_addr); end
      checks++; if (bus.stall_if !== 1'b1 || bus.stall_d !== 1'b1) begin errors++; $display("FAIL sim_stalls: got %b%b want 11", bus.stall_if, bus.stall_d); end
      bus.mem_ack = 1'b1;
      #1;
      checks++; if (bus.d_ready !== 1'b1 || bus.if_ready !== 1'b0) begin errors++; $display("FAIL sim_d_ready: got d=%b i=%b want 1 0", bus.d_ready, bus.if_ready); end
      tick();
      bus.d_req = 1'b0;
      bus.mem_ack = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL sim_idle: got %b want 0", bus.mem_req); end
      tick();
      checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL sim_grant_i: got %b want 01", bus.grant); end
      checks++; if (bus.mem_addr !== 32'h44 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL sim_addr_i: got %h we=%b want 44 0", bus.mem_addr, bus.mem_we); end
      bus.mem_ack = 1'b1;
      #1;
      checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL sim_if_ready: got %b want 1", bus.if_ready); end
      tick();
      bus.if_req = 1'b0;
      bus.mem_ack = 1'b0;
      #1;
   endtask

   task automatic test_starvation();
      logic [1:0] exp_grant [6];
      exp_grant = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
      bus.d_req = 1'b1;
      bus.d_we = 1'b0;
      bus.d_addr = 32'h0000_0180;
      bus.if_req = 1'b1;
      bus.if_addr = 32'h0000_0048;
      bus.mem_ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (bus.grant !== exp_grant[i]) begin errors++; $display("FAIL starve_grant[%0d]: got %b want %b", i, bus.grant, exp_grant[i]); end
         tick();
         checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL starve_gap[%0d]: got %b want 0", i, bus.mem_req); end
      end
      bus.d_req = 1'b0;
      bus.if_req = 1'b0;
      bus.mem_ack = 1'b0;
      tick();
   endtask

   task automatic test_wait_states();
      int stall_cycles;
      int ready_pulses;
      stall_cycles = 0;
      ready_pulses = 0;
      bus.d_req = 1'b1;
      bus.d_we = 1'b0;
      bus.d_addr = 32'h0000_0200;
      bus.mem_ack = 1'b0;
      #1;
      if (bus.stall_d === 1'b1) stall_cycles++;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin errors++; $display("FAIL ws_hold[%0d]: got req=%b addr=%h want 1 200", k, bus.mem_req, bus.mem_addr); end
         if (bus.stall_d === 1'b1) stall_cycles++;
         if (bus.d_ready === 1'b1) ready_pulses++;
      end
      tick();
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h1234_5678;
      #1;
      checks++; if (bus.d_rdata !== 32'h1234_5678 || bus.mem_addr !== 32'h200) begin errors++; $display("FAIL ws_data: got %h addr=%h want 12345678 200", bus.d_rdata, bus.mem_addr); end
      if (bus.stall_d === 1'b1) stall_cycles++;
      if (bus.d_ready === 1'b1) ready_pulses++;
      tick();
      bus.d_req = 1'b0;
      bus.mem_ack = 1'b0;
      #1;
      if (bus.d_ready === 1'b1) ready_pulses++;
      checks++; if (stall_cycles !== 4) begin errors++; $display("FAIL ws_stall_cycles: got %0d want 4", stall_cycles); end
      checks++; if (ready_pulses !== 1) begin errors++; $display("FAIL ws_ready_pulses: got %0d want 1", ready_pulses); end
   endtask

   task automatic test_reset_mid_busy();
      bus.d_req = 1'b1;
      bus.d_we = 1'b1;
      bus.d_addr = 32'h0000_0300;
      bus.d_wdata = 32'hCAFE_F00D;
      bus.mem_ack = 1'b0;
      tick();
      checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL rmb_busy: got %b want 10", bus.grant); end
      resetn = 1'b0;
      tick();
      checks++; if (bus.mem_req !== 1'b0 || bus.grant !== 2'b00) begin errors++; $display("FAIL rmb_abort: got req=%b grant=%b want 0 00", bus.mem_req, bus.grant); end
      checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rmb_addr: got %h want 0", bus.mem_addr); end
      resetn = 1'b1;
      bus.d_req = 1'b0;
      bus.mem_ack = 1'b1;
      #1;
      checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL rmb_late_ack: got %b want 0", bus.d_ready); end
      tick();
      checks++; if (bus.mem_req !== 1'b0 || bus.grant !== 2'b00 || bus.d_ready !== 1'b0) begin errors++; $display("FAIL rmb_idle: got req=%b grant=%b rdy=%b want 0 00 0", bus.mem_req, bus.grant, bus.d_ready); end
      bus.mem_ack = 1'b0;
      tick();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      resetn = 1'b0;
      bus.if_req = 1'b0;
      bus.if_addr = '0;
      bus.d_req = 1'b0;
      bus.d_we = 1'b0;
      bus.d_addr = '0;
      bus.d_wdata = '0;
      bus.mem_rdata = '0;
      bus.mem_ack = 1'b0;
      test_reset();
      test_if_only();
      test_simultaneous();
      test_starvation();
      test_wait_states();
      test_reset_mid_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
